mas_alu_addsub_pipe: RTL and testbench

//  Parametrised pipelined signed/unsigned adder-subtractor for the MAS ALU datapath.
//  - Generalises the single-cycle subtractor:
//    - runtime add/sub select
//    - optional signed saturation
//    - carry/overflow/zero/negative flags
//    - configurable pipeline depth
//    - valid/ready flow control on input and output
//  - Sits between the operand-issue logic and the ALU result mux.

---
 rtl/mas_alu_addsub_pipe.sv | 85 ++++++++
 tb/tb_mas_alu_addsub_pipe.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mas_alu_addsub_pipe.sv
// mas_alu_addsub_pipe: pipelined add/sub with optional signed saturation, flags and valid/ready flow control
module mas_alu_addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int SAT_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);
    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             ovf;
        logic             zero;
        logic             neg;
    } beat_t;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    logic             ovf_w;
    beat_t            nxt;
    beat_t            data [STAGES];
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;

    assign b_eff = sub ? ~op2 : op2;
    assign sum   = {1'b0, op1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    assign ovf_w = (op1[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
    assign r     = ((SAT_EN != 0) && sat && ovf_w)
                 ? (op1[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                 : sum[WIDTH-1:0];
    assign nxt   = '{res: r, carry: sub ? ~sum[WIDTH] : sum[WIDTH], ovf: ovf_w,
                     zero: r == '0, neg: r[WIDTH-1]};

    // A stage may load when it is empty or the stage after it is moving.
    always_comb begin
        logic a;
        a = out_ready || !v[STAGES-1];
        adv[STAGES-1] = a;
        for (int i = STAGES - 2; i >= 0; i--) begin
            a = a || !v[i];
            adv[i] = a;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < STAGES; i++) data[i] <= '0;
        end else begin
            if (adv[0]) begin
                v[0]    <= in_valid;
                data[0] <= nxt;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (adv[i]) begin
                    v[i]    <= v[i-1];
                    data[i] <= data[i-1];
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v[STAGES-1];
    assign res       = data[STAGES-1].res;
    assign carry     = data[STAGES-1].carry;
    assign ovf       = data[STAGES-1].ovf;
    assign zero      = data[STAGES-1].zero;
    assign neg       = data[STAGES-1].neg;
endmodule

// File: tb/tb_mas_alu_addsub_pipe.sv
// tb_mas_alu_addsub_pipe: directed checks of the add/sub pipe (8-bit, 2 stages) plus a 1-stage unsaturated copy
module tb_mas_alu_addsub_pipe;
    logic       clk = 1'b0;
    logic       rst_n, in_valid, out_ready, sub, sat;
    logic [7:0] op1, op2, res, res1;
    logic       in_ready, out_valid, carry, ovf, zero, neg;
    logic       in_ready1, out_valid1, carry1, ovf1, zero1, neg1;
    int         tests = 0;
    int         fails = 0;
    int         idx, cnt;

    mas_alu_addsub_pipe #(.WIDTH(8), .STAGES(2), .SAT_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .sub(sub), .sat(sat),
        .out_valid(out_valid), .out_ready(out_ready), .res(res),
        .carry(carry), .ovf(ovf), .zero(zero), .neg(neg)
    );

    mas_alu_addsub_pipe #(.WIDTH(8), .STAGES(1), .SAT_EN(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .op1(op1), .op2(op2), .sub(sub), .sat(sat),
        .out_valid(out_valid1), .out_ready(out_ready), .res(res1),
        .carry(carry1), .ovf(ovf1), .zero(zero1), .neg(neg1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // flags packed as {carry, ovf, zero, neg}
    task automatic vec(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic t, input logic [7:0] er, input logic [3:0] ef);
        int n;
        n = 0;
        op1 = a; op2 = b; sub = s; sat = t; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        while (!out_valid && n < 8) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, 1);
        chk({tag, "_res"}, res, er);
        chk({tag, "_flags"}, {carry, ovf, zero, neg}, ef);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op1 = '0; op2 = '0; sub = 1'b0; sat = 1'b0;
        repeat (2) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_res", res, 0);
        chk("rst_flags", {carry, ovf, zero, neg}, 0);
        chk("rst_ready", in_ready, 1);
        rst_n = 1'b1;

        // saturation disabled, single stage: result lands one edge after accept
        op1 = 8'h7F; op2 = 8'h01; sub = 1'b0; sat = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("s1_valid", out_valid1, 1);
        chk("s1_res", res1, 8'h80);
        chk("s1_ovf", ovf1, 1);
        chk("s2_not_yet", out_valid, 0);
        tick();
        chk("s2_valid", out_valid, 1);
        chk("s2_sat_res", res, 8'h7F);
        chk("s1_drained", out_valid1, 0);

        vec("add_ovf",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 4'b0101);
        vec("add_sat",  8'h7F, 8'h01, 1'b0, 1'b1, 8'h7F, 4'b0100);
        vec("add_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 4'b1010);
        vec("sub_borrow", 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 4'b1001);
        vec("sub_sat",  8'h80, 8'h01, 1'b1, 1'b1, 8'h80, 4'b0101);
        vec("sub_zero", 8'h05, 8'h05, 1'b1, 1'b0, 8'h00, 4'b0010);

        // streaming: beat k accepted at edge k, visible after edge k+1
        idx = 0;
        for (int k = 0; k < 13; k++) begin
            in_valid = (k < 10);
            op1 = 8'(k * 3); op2 = 8'(k); sub = 1'b0; sat = 1'b0;
            tick();
            chk("stream_valid", out_valid, 32'(k >= 1 && k <= 10));
            if (out_valid) begin
                chk("stream_res", res, 32'(8'(idx * 4)));
                idx++;
            end
        end
        in_valid = 1'b0;
        chk("stream_count", idx, 10);

        // backpressure: two beats fill the pipe, third waits
        out_ready = 1'b0; in_valid = 1'b1; op1 = 8'h11; op2 = 8'h01;
        tick();
        chk("bp_ready1", in_ready, 1);
        op1 = 8'h21;
        tick();
        chk("bp_ready2", in_ready, 0);
        chk("bp_valid", out_valid, 1);
        chk("bp_res", res, 8'h12);
        op1 = 8'h31;
        tick();
        chk("bp_hold_res", res, 8'h12);
        chk("bp_hold_ready", in_ready, 0);
        out_ready = 1'b1;
        #1;
        chk("bp_pop_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_out2_v", out_valid, 1);
        chk("bp_out2", res, 8'h22);
        tick();
        chk("bp_out3_v", out_valid, 1);
        chk("bp_out3", res, 8'h32);
        tick();
        chk("bp_empty", out_valid, 0);

        // reset with two beats in flight
        out_ready = 1'b0; in_valid = 1'b1; op1 = 8'h40; op2 = 8'h01;
        tick();
        op1 = 8'h50;
        tick();
        in_valid = 1'b0;
        chk("fl_full", out_valid, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("fl_rst_valid", out_valid, 0);
        chk("fl_rst_res", res, 0);
        chk("fl_rst_flags", {carry, ovf, zero, neg}, 0);
        chk("fl_rst_ready", in_ready, 1);
        out_ready = 1'b1;
        cnt = 0;
        repeat (4) begin
            tick();
            if (out_valid) cnt++;
        end
        chk("fl_no_stale", cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
